// File: rtl/load_store_unit_pkg.sv
// Shared widths, FSM state encodings and GPReg write-command codes for the load/store unit.
// The GPReg file decodes the same MI_* codes that the unit drives on mem_instruction.
// Widths are centralised here so the interface, timer and top agree by construction.
package load_store_unit_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int CNT_W  = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Only NOP and WRITE are ever driven; 2'b01/2'b10 are reserved.
  typedef enum logic [1:0] {
    MI_NOP   = 2'b00,
    MI_WRITE = 2'b11
  } mem_instr_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles the request, GPReg and memory signals of the load/store unit.
// slave is the unit's view; master is the view of the surrounding logic
// (requester, GPReg file and memory) that drives and observes it.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  // Request side
  logic       start;
  logic       op;
  addr_t      addr;
  sel_t       reg_sel;
  // GPReg side
  data_t      a;
  sel_t       sel_x;
  sel_t       sel_z;
  logic [1:0] mem_instruction;
  data_t      mem_data;
  // Memory side
  logic       mem_req;
  logic       mem_we;
  addr_t      mem_addr;
  data_t      mem_wdata;
  logic       mem_ack;
  data_t      mem_rdata;
  // Status
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  start, op, addr, reg_sel, a, mem_ack, mem_rdata,
    output sel_x, sel_z, mem_instruction, mem_data,
           mem_req, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport master (
    output start, op, addr, reg_sel, a, mem_ack, mem_rdata,
    input  sel_x, sel_z, mem_instruction, mem_data,
           mem_req, mem_we, mem_addr, mem_wdata, busy, done, err
  );

endinterface

// File: rtl/load_store_unit_req_timer.sv
// Counts REQ-state cycles starting at 1 and flags the TIMEOUT-th one.
// clear_i preloads the count of the first REQ cycle; enable_i advances it.
// expired_o is combinational from the count so the FSM can abort on that same edge.
module load_store_unit_req_timer
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT));

  // Next count: preload 1 while idle, step while requesting, hold once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CNT_W'(1);
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: moves one word between a GPReg and memory per Start strobe.
// IDLE -> REQ (held until MemAck or TIMEOUT cycles) -> DONE (one cycle) -> IDLE.
// All outputs are registered except sel_x, which follows reg_sel while idle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   lsu
);

  state_t     state_q;
  logic       op_q;
  sel_t       reg_sel_q;
  sel_t       sel_z_q;
  mem_instr_t mem_instr_q;
  data_t      mem_data_q;
  logic       mem_req_q;
  logic       mem_we_q;
  addr_t      mem_addr_q;
  data_t      mem_wdata_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic       expired;

  load_store_unit_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_req_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == ST_IDLE),
    .enable_i  (state_q == ST_REQ),
    .expired_o (expired)
  );

  // The GPReg read port must see the requested register in the Start cycle
  // so a store can capture its data without an extra cycle.
  assign lsu.sel_x           = (state_q == ST_IDLE) ? lsu.reg_sel : reg_sel_q;
  assign lsu.sel_z           = sel_z_q;
  assign lsu.mem_instruction = mem_instr_q;
  assign lsu.mem_data        = mem_data_q;
  assign lsu.mem_req         = mem_req_q;
  assign lsu.mem_we          = mem_we_q;
  assign lsu.mem_addr        = mem_addr_q;
  assign lsu.mem_wdata       = mem_wdata_q;
  assign lsu.busy            = busy_q;
  assign lsu.done            = done_q;
  assign lsu.err             = err_q;

  // FSM with registered outputs; reset aborts any operation without a GPReg write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      reg_sel_q   <= '0;
      sel_z_q     <= '0;
      mem_instr_q <= MI_NOP;
      mem_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lsu.start) begin
            op_q       <= lsu.op;
            reg_sel_q  <= lsu.reg_sel;
            mem_addr_q <= lsu.addr;
            if (lsu.op) begin
              mem_wdata_q <= lsu.a;
            end
            mem_req_q <= 1'b1;
            mem_we_q  <= lsu.op;
            busy_q    <= 1'b1;
            state_q   <= ST_REQ;
          end
        end

        ST_REQ: begin
          // An ack on the timeout cycle still counts as success.
          if (lsu.mem_ack) begin
            if (!op_q) begin
              mem_data_q  <= lsu.mem_rdata;
              mem_instr_q <= MI_WRITE;
              sel_z_q     <= reg_sel_q;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end else if (expired) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= ST_DONE;
          end
        end

        ST_DONE: begin
          mem_instr_q <= MI_NOP;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          mem_instr_q <= MI_NOP;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small GPReg file around it.
// Inputs change 2 ns after each rising edge; outputs are checked at that same point.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // GPReg file surrounding the unit
  logic [31:0] gpr [8];
  logic        gpr_clr;
  logic        pre_we;
  logic [2:0]  pre_sel;
  logic [31:0] pre_dat;
  int          wr_cnt = 0;
  int          bad_mi = 0;
  int          reqn;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.a = gpr[bus.sel_x];

  always @(posedge clk) begin
    if (gpr_clr) begin
      for (int i = 0; i < 8; i++) gpr[i] <= 32'd0;
    end else if (pre_we) begin
      gpr[pre_sel] <= pre_dat;
    end else if (bus.mem_instruction == 2'b11) begin
      gpr[bus.sel_z] <= bus.mem_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_instruction == 2'b01 || bus.mem_instruction == 2'b10) bad_mi <= bad_mi + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; gpr_clr = 1'b1; pre_we = 1'b0; pre_sel = 3'd0; pre_dat = 32'd0;
    bus.start = 1'b0; bus.op = 1'b0; bus.addr = 16'h0; bus.reg_sel = 3'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    cyc(); cyc();
    // Reset state
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_err",     32'(bus.err),     32'd0);
    chk("rst_mi",      32'(bus.mem_instruction), 32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_data",  bus.mem_data,  32'd0);
    chk("rst_sel_z",     32'(bus.sel_z), 32'd0);
    rst = 1'b0; gpr_clr = 1'b0;
    bus.reg_sel = 3'd5;
    #1 chk("idle_sel_x_follows", 32'(bus.sel_x), 32'd5);
    cyc();

    // Load: ack on 3rd REQ cycle, Done at cycle 4
    bus.start = 1'b1; bus.op = 1'b0; bus.addr = 16'h0010; bus.reg_sel = 3'd1;
    cyc(); // cycle 1
    bus.start = 1'b0; bus.reg_sel = 3'd6;
    #1;
    chk("ld_req",      32'(bus.mem_req), 32'd1);
    chk("ld_we",       32'(bus.mem_we),  32'd0);
    chk("ld_addr",     32'(bus.mem_addr), 32'h0010);
    chk("ld_busy",     32'(bus.busy),    32'd1);
    chk("ld_sel_x_latched", 32'(bus.sel_x), 32'd1);
    cyc(); // cycle 2
    cyc(); // cycle 3
    chk("ld_req_c3", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'd44;
    cyc(); // cycle 4
    bus.mem_ack = 1'b0;
    chk("ld_done",   32'(bus.done), 32'd1);
    chk("ld_err",    32'(bus.err),  32'd0);
    chk("ld_mi",     32'(bus.mem_instruction), 32'd3);
    chk("ld_sel_z",  32'(bus.sel_z), 32'd1);
    chk("ld_data",   bus.mem_data, 32'd44);
    chk("ld_req_off", 32'(bus.mem_req), 32'd0);
    cyc(); // cycle 5
    chk("ld_done_pulse", 32'(bus.done), 32'd0);
    chk("ld_mi_nop",     32'(bus.mem_instruction), 32'd0);
    chk("ld_idle_busy",  32'(bus.busy), 32'd0);
    bus.reg_sel = 3'd1;
    #1 chk("ld_gpr_read", bus.a, 32'd44);
    chk("ld_wr_cnt", 32'(wr_cnt), 32'd1);

    // Store: reg2 = 37, ack on 1st REQ cycle, Done at cycle 2
    pre_we = 1'b1; pre_sel = 3'd2; pre_dat = 32'd37;
    cyc();
    pre_we = 1'b0;
    bus.start = 1'b1; bus.op = 1'b1; bus.addr = 16'h0020; bus.reg_sel = 3'd2;
    cyc(); // cycle 1
    bus.start = 1'b0;
    chk("st_req",   32'(bus.mem_req), 32'd1);
    chk("st_we",    32'(bus.mem_we),  32'd1);
    chk("st_addr",  32'(bus.mem_addr), 32'h0020);
    chk("st_wdata", bus.mem_wdata, 32'd37);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    cyc(); // cycle 2
    bus.mem_ack = 1'b0;
    chk("st_done", 32'(bus.done), 32'd1);
    chk("st_err",  32'(bus.err),  32'd0);
    chk("st_mi",   32'(bus.mem_instruction), 32'd0);
    chk("st_data_kept", bus.mem_data, 32'd44);
    cyc();
    chk("st_wr_cnt", 32'(wr_cnt), 32'd1);

    // Timeout: no ack -> 15 REQ cycles, Done+Err at cycle 16
    bus.start = 1'b1; bus.op = 1'b0; bus.addr = 16'h0030; bus.reg_sel = 3'd3;
    reqn = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      bus.start = 1'b0;
      if (bus.mem_req) reqn++;
    end
    cyc(); // cycle 16
    chk("to_req_cycles", 32'(reqn), 32'd15);
    chk("to_req_off", 32'(bus.mem_req), 32'd0);
    chk("to_done",    32'(bus.done), 32'd1);
    chk("to_err",     32'(bus.err),  32'd1);
    chk("to_mi",      32'(bus.mem_instruction), 32'd0);
    cyc(); // cycle 17
    chk("to_err_pulse", 32'(bus.err), 32'd0);
    chk("to_idle",      32'(bus.busy), 32'd0);
    chk("to_wr_cnt",    32'(wr_cnt), 32'd1);

    // Ack on the 15th REQ cycle wins over timeout
    bus.start = 1'b1; bus.op = 1'b0; bus.addr = 16'h0031; bus.reg_sel = 3'd3;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      bus.start = 1'b0;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    cyc(); // cycle 16
    bus.mem_ack = 1'b0;
    chk("to15_done", 32'(bus.done), 32'd1);
    chk("to15_err",  32'(bus.err),  32'd0);
    chk("to15_mi",   32'(bus.mem_instruction), 32'd3);
    chk("to15_data", bus.mem_data, 32'h1234_5678);
    cyc();
    bus.reg_sel = 3'd3;
    #1 chk("to15_gpr_read", bus.a, 32'h1234_5678);
    chk("to15_wr_cnt", 32'(wr_cnt), 32'd2);

    // Start during REQ and DONE ignored; Start in first IDLE after DONE accepted
    bus.start = 1'b1; bus.op = 1'b0; bus.addr = 16'h0040; bus.reg_sel = 3'd4;
    cyc(); // cycle 1 (REQ)
    bus.start = 1'b1; bus.op = 1'b1; bus.addr = 16'h0099;
    cyc(); // cycle 2 (REQ)
    bus.start = 1'b0;
    chk("ign_req_addr", 32'(bus.mem_addr), 32'h0040);
    chk("ign_req_we",   32'(bus.mem_we), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55;
    cyc(); // cycle 3 (DONE)
    bus.mem_ack = 1'b0;
    chk("ign_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1; bus.op = 1'b1; bus.addr = 16'h0077; bus.reg_sel = 3'd2;
    cyc(); // cycle 4 (IDLE): Start from DONE not queued
    chk("ign_done_start_busy", 32'(bus.busy), 32'd0);
    chk("ign_done_start_req",  32'(bus.mem_req), 32'd0);
    cyc(); // cycle 5: Start in first IDLE cycle accepted
    bus.start = 1'b0;
    chk("acc_req",   32'(bus.mem_req), 32'd1);
    chk("acc_we",    32'(bus.mem_we), 32'd1);
    chk("acc_addr",  32'(bus.mem_addr), 32'h0077);
    chk("acc_wdata", bus.mem_wdata, 32'd37);
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack = 1'b0;
    chk("acc_done", 32'(bus.done), 32'd1);
    cyc();
    chk("ign_wr_cnt", 32'(wr_cnt), 32'd3);

    // MemAck in IDLE ignored
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack = 1'b0;
    chk("idle_ack_done", 32'(bus.done), 32'd0);
    chk("idle_ack_busy", 32'(bus.busy), 32'd0);

    // Reset on 2nd REQ cycle of a load aborts it
    bus.start = 1'b1; bus.op = 1'b0; bus.addr = 16'h0050; bus.reg_sel = 3'd5;
    cyc(); // cycle 1
    bus.start = 1'b0;
    cyc(); // cycle 2
    rst = 1'b1;
    cyc(); // cycle 3
    rst = 1'b0;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_req",  32'(bus.mem_req), 32'd0);
    chk("ab_done", 32'(bus.done), 32'd0);
    chk("ab_mi",   32'(bus.mem_instruction), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD;
    cyc();
    bus.mem_ack = 1'b0;
    chk("ab_late_ack_done", 32'(bus.done), 32'd0);
    chk("ab_late_ack_mi",   32'(bus.mem_instruction), 32'd0);
    cyc();
    chk("ab_wr_cnt", 32'(wr_cnt), 32'd3);
    chk("bad_mi_codes", 32'(bad_mi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
